// File: rtl/picorv_stream_mmio_pkg.sv
// Shared definitions for the picorv32 stream MMIO bridge: register offsets,
// CTRL bit positions and the bus-response FSM state type.
package picorv_stream_pkg;

   localparam logic [3:0] OFF_TX_DATA = 4'h0;
   localparam logic [3:0] OFF_RX_DATA = 4'h4;
   localparam logic [3:0] OFF_STATUS  = 4'h8;
   localparam logic [3:0] OFF_CTRL    = 4'hC;

   localparam int CTRL_RX_IRQ_EN = 0;
   localparam int CTRL_TX_IRQ_EN = 1;
   localparam int CTRL_FLUSH     = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

endpackage

// File: rtl/picorv_stream_mmio_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a flush
// that wins over any same-cycle push or pop.
module stream_fifo #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 8,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/picorv_stream_mmio.sv
// picorv32 native-bus responder bridging CPU loads/stores to an inbound and an
// outbound 32-bit valid/ready stream through two small FIFOs.
module picorv_stream_mmio
   import picorv_stream_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   input  logic        val_in,
   input  logic [31:0] din,
   output logic        ready_upward,
   output logic        val_out,
   output logic [31:0] dout,
   input  logic        ready_downward,
   output logic        irq
);

   state_e      state_q, state_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        irq_q, irq_d;

   logic             rx_full, rx_empty, rx_push, rx_pop;
   logic             tx_full, tx_empty, tx_push, tx_pop;
   logic [CNT_W-1:0] rx_count, tx_count;
   logic [31:0]      rx_dout;
   logic             flush;

   logic        hit;
   logic        is_write;
   logic        completable;
   logic [3:0]  reg_off;
   logic [31:0] status_word;
   logic        unused_addr_lsb;

   assign hit             = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign is_write        = |mem_wstrb;
   assign reg_off         = {mem_addr[3:2], 2'b00};
   assign unused_addr_lsb = ^mem_addr[1:0];

   assign status_word = {8'h00, 8'(tx_count), 8'(rx_count), 4'h0,
                         tx_full, tx_empty, rx_full, rx_empty};

   assign ready_upward = !rx_full;
   assign val_out      = !tx_empty;
   assign rx_push      = val_in && !rx_full;
   assign tx_pop       = !tx_empty && ready_downward;

   assign mem_ready = (state_q == RESP);
   assign mem_rdata = mem_rdata_q;
   assign irq       = irq_q;

   // Only data-register accesses can stall: a store needs TX space, a load needs RX data.
   always_comb begin
      completable = 1'b1;
      case (reg_off)
         OFF_TX_DATA: completable = !is_write || !tx_full;
         OFF_RX_DATA: completable = is_write || !rx_empty;
         default:     completable = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_rdata_d = '0;
      ctrl_d      = ctrl_q;
      tx_push     = 1'b0;
      rx_pop      = 1'b0;
      flush       = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit && completable) begin
               state_d = RESP;
               case (reg_off)
                  OFF_TX_DATA: tx_push = is_write;
                  OFF_RX_DATA: begin
                     if (!is_write) begin
                        rx_pop      = 1'b1;
                        mem_rdata_d = rx_dout;
                     end
                  end
                  OFF_STATUS: begin
                     if (!is_write) mem_rdata_d = status_word;
                  end
                  OFF_CTRL: begin
                     if (is_write) begin
                        ctrl_d = {mem_wdata[CTRL_TX_IRQ_EN], mem_wdata[CTRL_RX_IRQ_EN]};
                        flush  = mem_wdata[CTRL_FLUSH];
                     end else begin
                        mem_rdata_d = {30'h0, ctrl_q};
                     end
                  end
                  default: ;
               endcase
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign irq_d = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty) ||
                  (ctrl_q[CTRL_TX_IRQ_EN] && !tx_full);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_rdata_q <= '0;
         ctrl_q      <= '0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_rdata_q <= mem_rdata_d;
         ctrl_q      <= ctrl_d;
         irq_q       <= irq_d;
      end
   end

   stream_fifo #(
      .DATA_W (32),
      .DEPTH  (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .flush (flush),
      .din   (din),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   stream_fifo #(
      .DATA_W (32),
      .DEPTH  (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .flush (flush),
      .din   (mem_wdata),
      .dout  (dout),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

endmodule
